// File: rtl/ft600_bus_pkg.sv
// ft600_bus_pkg: shared widths, bus-phase encoding and drive constants for the FT600 device model.
package ft600_bus_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int BE_W_DEF   = 2;
    localparam logic BE_DRIVE_BIT = 1'b1;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_TURN   = 2'd1,
        ST_RD_ACTIVE = 2'd2,
        ST_WR        = 2'd3
    } bus_state_t;
endpackage

// File: rtl/ft600_sync_fifo.sv
// ft600_sync_fifo: first-word fall-through FIFO with full/empty registered from next occupancy.
module ft600_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic          push_ok, pop_ok;
    assign pop_ok     = pop && !empty;
    // A push into a full FIFO is taken only when the head leaves on the same edge.
    assign push_ok    = push && (!full || pop_ok);
    assign count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    assign dout       = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count_next;
            full   <= count_next == (AW+1)'(DEPTH);
            empty  <= count_next == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ft600_device_model.sv
// ft600_device_model: chip-side FT600 245-sync FIFO bus model with a host stream port.
module ft600_device_model
    import ft600_bus_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BE_W     = BE_W_DEF,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic              i_ft_clk,
    input  logic              i_rst_n,
    output logic              o_ft_rxf_n,
    output logic              o_ft_txe_n,
    input  logic              i_ft_oe_n,
    input  logic              i_ft_rd_n,
    input  logic              i_ft_wr_n,
    input  logic [DATA_W-1:0] i_ft_data,
    input  logic [BE_W-1:0]   i_ft_be,
    output logic [DATA_W-1:0] o_ft_data,
    output logic [BE_W-1:0]   o_ft_be,
    output logic              o_ft_drive,
    input  logic              i_host_wr_valid,
    input  logic [DATA_W-1:0] i_host_wr_data,
    output logic              o_host_wr_ready,
    output logic              o_host_rd_valid,
    output logic [DATA_W-1:0] o_host_rd_data,
    output logic [BE_W-1:0]   o_host_rd_be,
    input  logic              i_host_rd_ready,
    output logic              o_err_contention,
    output logic              o_err_proto,
    output logic [15:0]       o_rd_count,
    output logic [15:0]       o_wr_count
);
    bus_state_t state, state_next;
    logic rx_pop, tx_push, rx_full, tx_empty, contention;
    assign contention = !i_ft_oe_n && !i_ft_wr_n;
    assign rx_pop     = !i_ft_oe_n && !i_ft_rd_n && !o_ft_rxf_n;
    // The device is driving the bus while OE# is low, so a write then is contention, not a capture.
    assign tx_push    = !i_ft_wr_n && !o_ft_txe_n && i_ft_oe_n;
    assign o_ft_drive = !i_ft_oe_n;
    assign o_ft_be    = {BE_W{BE_DRIVE_BIT}};
    assign o_host_wr_ready = !rx_full;
    assign o_host_rd_valid = !tx_empty;
    ft600_sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
        .clk(i_ft_clk), .rst_n(i_rst_n),
        .push(i_host_wr_valid), .din(i_host_wr_data), .pop(rx_pop),
        .dout(o_ft_data), .full(rx_full), .empty(o_ft_rxf_n)
    );
    ft600_sync_fifo #(.W(DATA_W + BE_W), .DEPTH(TX_DEPTH)) u_tx (
        .clk(i_ft_clk), .rst_n(i_rst_n),
        .push(tx_push), .din({i_ft_be, i_ft_data}), .pop(i_host_rd_ready),
        .dout({o_host_rd_be, o_host_rd_data}), .full(o_ft_txe_n), .empty(tx_empty)
    );
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      state_next = !i_ft_oe_n ? ST_RD_TURN : tx_push ? ST_WR : ST_IDLE;
            ST_RD_TURN:   state_next = i_ft_oe_n ? ST_IDLE : !i_ft_rd_n ? ST_RD_ACTIVE : ST_RD_TURN;
            ST_RD_ACTIVE: state_next = i_ft_oe_n ? ST_IDLE : ST_RD_ACTIVE;
            ST_WR:        state_next = i_ft_wr_n ? ST_IDLE : ST_WR;
            default:      state_next = ST_IDLE;
        endcase
        if (contention) state_next = ST_IDLE;
    end
    always_ff @(posedge i_ft_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ST_IDLE;
            o_err_contention <= 1'b0;
            o_err_proto      <= 1'b0;
            o_rd_count       <= '0;
            o_wr_count       <= '0;
        end else begin
            state            <= state_next;
            o_err_contention <= o_err_contention || contention;
            o_err_proto      <= o_err_proto || (!i_ft_rd_n && i_ft_oe_n);
            o_rd_count       <= o_rd_count + 16'(rx_pop);
            o_wr_count       <= o_wr_count + 16'(tx_push);
        end
    end
endmodule
